fp_unpack: RTL and testbench

FP_UNPACK -- requirements
Module: fp_unpack

---
 rtl/fp_unpack_if.sv | 41 ++++
 rtl/fp_unpack.sv | 121 ++++++++++++
 tb/tb_fp_unpack.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_unpack_if.sv
// fp_unpack_if: operand/result bus of the IEEE unpacker.
//   in_valid/in_ready/in_word            - operand handshake (producer -> unpacker)
//   out_valid/out_ready                  - result handshake  (unpacker -> consumer)
//   out_sign/out_exp/out_sig             - unpacked sign, two's-complement biased exponent,
//                                          significand with explicit hidden bit
//   out_zero/out_inf/out_nan/out_snan/out_denorm - operand class flags
//   busy                                 - denormal normalization in progress
// modport slave  : the unpacker side
// modport master : the producer/consumer (test) side
`timescale 1ns/1ps
interface fp_unpack_if #(
   parameter int WEXP = 8,
   parameter int WSIG = 23
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WEXP+WSIG:0]   in_word;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_sign;
   logic [WEXP+1:0]      out_exp;
   logic [WSIG:0]        out_sig;
   logic                 out_zero;
   logic                 out_inf;
   logic                 out_nan;
   logic                 out_snan;
   logic                 out_denorm;
   logic                 busy;

   modport slave (
      input  in_valid, in_word, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_sig,
             out_zero, out_inf, out_nan, out_snan, out_denorm, busy
   );

   modport master (
      output in_valid, in_word, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_sig,
             out_zero, out_inf, out_nan, out_snan, out_denorm, busy
   );
endinterface

// File: rtl/fp_unpack.sv
// fp_unpack: splits an IEEE-754 style word into sign, exponent and significand
// with the hidden bit made explicit, and classifies the operand.
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high
//   bus   - fp_unpack_if.slave (operand/result handshakes, fields, flags, busy)
// Normal, zero, infinity and NaN results appear one cycle after accept.
// Build macro FP_UNPACK_DENORM_NORM_EN: when defined, denormals are normalized by a
// one-bit-per-cycle left shift (SHIFT state); when undefined they are flushed to
// zero with out_denorm set, and busy is tied low.
`timescale 1ns/1ps
module fp_unpack #(
   parameter int WEXP = 8,
   parameter int WSIG = 23
) (
   input  logic        clk,
   input  logic        reset,
   fp_unpack_if.slave  bus
);

   localparam logic [WEXP+1:0] EXP_ONE = {{(WEXP+1){1'b0}}, 1'b1};

   logic            sgn;
   logic [WEXP-1:0] e;
   logic [WSIG-1:0] frac;
   logic            e_zero, e_ones, f_zero;
   logic            accept;

   assign {sgn, e, frac} = bus.in_word;
   assign e_zero = (e == '0);
   assign e_ones = &e;
   assign f_zero = (frac == '0);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
   state_t state;

`ifdef FP_UNPACK_DENORM_NORM_EN
   state_t state_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Leave SHIFT on the edge whose shift brings a 1 into the significand MSB.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept && e_zero && !f_zero) state_nx = SHIFT;
         SHIFT:   if (bus.out_sig[WSIG-1])         state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign bus.busy = (state == SHIFT);
`else
   assign state    = IDLE;
   assign bus.busy = 1'b0;
`endif

   // Gated by reset so nothing is taken while the block is held in reset.
   assign bus.in_ready = !reset && (state == IDLE) && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid  <= 1'b0;
         bus.out_sign   <= 1'b0;
         bus.out_exp    <= '0;
         bus.out_sig    <= '0;
         bus.out_zero   <= 1'b0;
         bus.out_inf    <= 1'b0;
         bus.out_nan    <= 1'b0;
         bus.out_snan   <= 1'b0;
         bus.out_denorm <= 1'b0;
      end else if (accept) begin
         bus.out_sign   <= sgn;
         bus.out_zero   <= 1'b0;
         bus.out_inf    <= 1'b0;
         bus.out_nan    <= 1'b0;
         bus.out_snan   <= 1'b0;
         bus.out_denorm <= 1'b0;
         bus.out_valid  <= 1'b1;
         if (e_ones) begin
            bus.out_exp  <= {2'b00, e};
            bus.out_sig  <= {1'b1, frac};
            bus.out_inf  <= f_zero;
            bus.out_nan  <= !f_zero;
            // Quiet bit is the fraction MSB; a NaN with it clear is signaling.
            bus.out_snan <= !f_zero && !frac[WSIG-1];
         end else if (!e_zero) begin
            bus.out_exp <= {2'b00, e};
            bus.out_sig <= {1'b1, frac};
         end else if (f_zero) begin
            bus.out_zero <= 1'b1;
            bus.out_exp  <= '0;
            bus.out_sig  <= '0;
         end else begin
            bus.out_denorm <= 1'b1;
`ifdef FP_UNPACK_DENORM_NORM_EN
            // Denormals carry an effective exponent of 1; shifting starts from there.
            bus.out_exp   <= EXP_ONE;
            bus.out_sig   <= {1'b0, frac};
            bus.out_valid <= 1'b0;
`else
            bus.out_zero  <= 1'b1;
            bus.out_exp   <= '0;
            bus.out_sig   <= '0;
`endif
         end
`ifdef FP_UNPACK_DENORM_NORM_EN
      end else if (state == SHIFT) begin
         bus.out_sig <= {bus.out_sig[WSIG-1:0], 1'b0};
         bus.out_exp <= bus.out_exp - EXP_ONE;
         if (bus.out_sig[WSIG-1]) bus.out_valid <= 1'b1;
`endif
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_unpack.sv
`timescale 1ns/1ps
module tb_fp_unpack;
   localparam int WEXP = 8;
   localparam int WSIG = 23;

   logic clk = 1'b0;
   logic reset;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   fp_unpack_if #(.WEXP(WEXP), .WSIG(WSIG)) bus ();

   fp_unpack #(.WEXP(WEXP), .WSIG(WSIG)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [39:0] vec;
      int          lat;
      int          nbusy;
   } ref_t;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      nvec++;
      if (obs !== want) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [39:0] obsvec();
      return {bus.out_sign, bus.out_exp, bus.out_sig, bus.out_zero, bus.out_inf,
              bus.out_nan, bus.out_snan, bus.out_denorm};
   endfunction

   // Reference: classify by field values, normalize denormals by doubling the
   // fraction until it reaches the hidden-bit weight.
   function automatic ref_t model(input logic [31:0] w);
      ref_t        r;
      int          e, f, ex, s;
      longint      sg;
      bit          z, i, n, sn, d;
      logic [9:0]  e10;
      logic [23:0] s24;
      e = int'(w[30:23]);
      f = int'(w[22:0]);
      r.lat = 1; r.nbusy = 0;
      ex = 0; sg = 0; z = 0; i = 0; n = 0; sn = 0; d = 0;
      if (e == 255) begin
         ex = 255; sg = 64'd8388608 + f;
         i = (f == 0); n = (f != 0); sn = n && (f < 4194304);
      end else if (e > 0) begin
         ex = e; sg = 64'd8388608 + f;
      end else if (f == 0) begin
         z = 1;
      end else begin
         d = 1;
`ifdef FP_UNPACK_DENORM_NORM_EN
         sg = f; s = 0;
         while (sg < 64'd8388608) begin sg = sg * 2; s++; end
         ex = 1 - s; r.lat = s + 1; r.nbusy = s;
`else
         z = 1;
`endif
      end
      e10 = ex[9:0];
      s24 = sg[23:0];
      r.vec = {w[31], e10, s24, z, i, n, sn, d};
      return r;
   endfunction

   function automatic logic [31:0] rand_word();
      int cls, sh;
      logic [22:0] f;
      cls = $urandom_range(0, 5);
      f = 23'($urandom);
      case (cls)
         0: return {1'($urandom), 8'($urandom_range(1, 254)), f};
         1: return {1'($urandom), 31'd0};
         2: return {1'($urandom), 8'hFF, 23'd0};
         3: begin if (f == 0) f = 1; return {1'($urandom), 8'hFF, f}; end
         4: begin
            sh = $urandom_range(0, 22);
            f = f >> sh;
            if (f == 0) f = 1;
            return {1'($urandom), 8'h00, f};
         end
         default: return $urandom;
      endcase
   endfunction

   // Offer one word with out_ready high, then check latency, busy cycles and result.
   task automatic run_op(input string tag, input logic [31:0] w);
      ref_t r;
      int   n, lat, nb;
      r = model(w);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_word  = w;
      n = 0;
      while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
      chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_word  = $urandom;
      lat = 0; nb = 0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.busy) nb++;
      end while (!bus.out_valid && lat < 64);
      chk({tag, "_lat"},  64'(lat), 64'(r.lat));
      chk({tag, "_busy"}, 64'(nb),  64'(r.nbusy));
      chk({tag, "_res"},  64'(obsvec()), 64'(r.vec));
   endtask

   initial begin
      logic [31:0] w, prev, wa, wb;
      int nb, n, nv;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_word  = '0;
      bus.out_ready = 1'b1;
      #1;
      chk("rst_out",  64'(obsvec()), 64'd0);
      chk("rst_ov",   64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_rdy",  64'(bus.in_ready), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1 chk("rst_rdy_after", 64'(bus.in_ready), 64'd1);

      // Directed operands
      run_op("one", 32'h3F800000);
      chk("one_exp", 64'(bus.out_exp), 64'h07F);
      chk("one_sig", 64'(bus.out_sig), 64'h800000);
      run_op("minden", 32'h00000001);
`ifdef FP_UNPACK_DENORM_NORM_EN
      chk("minden_exp", 64'(bus.out_exp), 64'h3EA);
      chk("minden_sig", 64'(bus.out_sig), 64'h800000);
      chk("minden_dn",  64'(bus.out_denorm), 64'd1);
`else
      chk("minden_z",   64'(bus.out_zero), 64'd1);
      chk("minden_dn",  64'(bus.out_denorm), 64'd1);
      chk("minden_sig", 64'(bus.out_sig), 64'd0);
`endif
      run_op("halfden", 32'h00400000);
`ifdef FP_UNPACK_DENORM_NORM_EN
      chk("halfden_exp", 64'(bus.out_exp), 64'h000);
`endif
      run_op("qnan", 32'h7FC00000);
      chk("qnan_snan", 64'(bus.out_snan), 64'd0);
      run_op("snan", 32'h7F800001);
      chk("snan_snan", 64'(bus.out_snan), 64'd1);
      run_op("ninf", 32'hFF800000);
      chk("ninf_sign", 64'(bus.out_sign), 64'd1);
      run_op("pzero",  32'h00000000);
      run_op("nzero",  32'h80000000);
      run_op("maxn",   32'h7F7FFFFF);
      run_op("minn",   32'h00800000);
      run_op("maxden", 32'h807FFFFF);

      // Stall: result held, input refused, then released with a new accept
      @(negedge clk);
      wa = 32'h40490FDB; wb = 32'hC0000000;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_word   = wa;
      @(posedge clk); #1;
      bus.in_word = wb;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_rdy", 64'(bus.in_ready), 64'd0);
         chk("stall_ov",  64'(bus.out_valid), 64'd1);
         chk("stall_res", 64'(obsvec()), 64'(model(wa).vec));
      end
      bus.out_ready = 1'b1;
      #1 chk("stall_rel_rdy", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("stall_b_ov",  64'(bus.out_valid), 64'd1);
      chk("stall_b_res", 64'(obsvec()), 64'(model(wb).vec));

      // Back-to-back latency-1 stream
      @(negedge clk);
      prev = '0;
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            chk("b2b_ov",  64'(bus.out_valid), 64'd1);
            chk("b2b_res", 64'(obsvec()), 64'(model(prev).vec));
         end
         if (i < 8) begin
            w = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            bus.in_valid = 1'b1;
            bus.in_word  = w;
            #1 chk("b2b_rdy", 64'(bus.in_ready), 64'd1);
            prev = w;
            @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;

`ifdef FP_UNPACK_DENORM_NORM_EN
      // Reset in the middle of a normalization
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_word  = 32'h00000001;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      nb = 0; n = 0;
      while (nb < 10 && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.busy) nb++;
      end
      chk("midrst_busy10", 64'(nb), 64'd10);
      reset = 1'b1;
      #1;
      chk("midrst_out",  64'(obsvec()), 64'd0);
      chk("midrst_ov",   64'(bus.out_valid), 64'd0);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_rdy",  64'(bus.in_ready), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("midrst_rdy_after", 64'(bus.in_ready), 64'd1);
      nv = 0;
      repeat (30) begin @(negedge clk); if (bus.out_valid) nv++; end
      chk("midrst_noresult", 64'(nv), 64'd0);
`else
      // Reset while a result is being held
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_word   = 32'hBF800000;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("hldrst_out", 64'(obsvec()), 64'd0);
      chk("hldrst_ov",  64'(bus.out_valid), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      #1 chk("hldrst_rdy_after", 64'(bus.in_ready), 64'd1);
      nv = 0;
      repeat (5) begin @(negedge clk); if (bus.out_valid) nv++; end
      chk("hldrst_noresult", 64'(nv), 64'd0);
`endif

      // Randomized operands against the model
      for (int i = 0; i < 200; i++) run_op("rnd", rand_word());

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
